operand_fetch_system: RTL and testbench

Operand-fetch stage of the 16-bit datapath, directly upstream of the ALU stage. Holds the 16×16-bit register file, reads two source operands, extends the 8-bit immediate, and registers A, B, Imm, ALUsrc and ALUop into a pipeline register that drives the ALU stage's inputs. Accepts the writeback port from the downstream end of the pipe. Supports stall, flush and same-cycle write-to-read bypass.

---
 rtl/operand_fetch_system.sv | 114 +++++++++++
 tb/tb_operand_fetch_system.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_system.sv
// Operand-fetch stage: 16x16 register file with write-to-read bypass, immediate
// extension, and the pipeline register that feeds the ALU stage.
module operand_fetch_system #(
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic [7:0]            imm_in,
  input  logic                  imm_signed,
  input  logic                  alusrc_in,
  input  logic [2:0]            aluop_in,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [15:0]           WriteData,
  output logic [15:0]           A,
  output logic [15:0]           B,
  output logic [15:0]           Imm,
  output logic                  ALUsrc,
  output logic [2:0]            ALUop,
  output logic                  valid_out
);

  // Pipeline handshake: valid_out marks a real instruction in the register;
  // flush loads a bubble (wins over stall), stall holds everything, otherwise
  // the register loads each edge. valid_in=0 still loads the data fields.

  logic [15:0] rf_q [REG_COUNT];

  logic        wr_en;
  logic [15:0] rd_a, rd_b, imm_ext;

  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] imm_q, imm_d;
  logic        alusrc_q, alusrc_d;
  logic [2:0]  aluop_q, aluop_d;
  logic        valid_q, valid_d;

  assign wr_en = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[WriteReg] <= WriteData;
    end
  end

  // Bypass takes the in-flight writeback; r0 is forced to zero on both paths.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs_addr != '0) rd_a = (wr_en && WriteReg == rs_addr) ? WriteData : rf_q[rs_addr];
    if (rt_addr != '0) rd_b = (wr_en && WriteReg == rt_addr) ? WriteData : rf_q[rt_addr];
  end

  assign imm_ext = imm_signed ? {{8{imm_in[7]}}, imm_in} : {8'h00, imm_in};

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alusrc_d = alusrc_q;
    aluop_d  = aluop_q;
    valid_d  = valid_q;
    if (flush) begin
      a_d      = '0;
      b_d      = '0;
      imm_d    = '0;
      alusrc_d = 1'b0;
      aluop_d  = '0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      a_d      = rd_a;
      b_d      = rd_b;
      imm_d    = imm_ext;
      alusrc_d = alusrc_in;
      aluop_d  = aluop_in;
      valid_d  = valid_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      aluop_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      alusrc_q <= alusrc_d;
      aluop_q  <= aluop_d;
      valid_q  <= valid_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Imm       = imm_q;
  assign ALUsrc    = alusrc_q;
  assign ALUop     = aluop_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_operand_fetch_system.sv
// Directed bench for operand_fetch_system: register file, bypass, immediate,
// stall/flush priority and asynchronous reset, with hand-computed expectations.
module tb_operand_fetch_system;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rs_addr, rt_addr;
  logic [7:0]  imm_in;
  logic        imm_signed, alusrc_in, valid_in, stall, flush;
  logic [2:0]  aluop_in;
  logic        RegWrite;
  logic [3:0]  WriteReg;
  logic [15:0] WriteData;
  logic [15:0] A, B, Imm;
  logic        ALUsrc, valid_out;
  logic [2:0]  ALUop;

  int total = 0;
  int bad   = 0;

  operand_fetch_system #(.REG_COUNT(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .imm_in(imm_in), .imm_signed(imm_signed), .alusrc_in(alusrc_in),
    .aluop_in(aluop_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .A(A), .B(B), .Imm(Imm), .ALUsrc(ALUsrc), .ALUop(ALUop), .valid_out(valid_out)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [15:0] d);
    RegWrite = 1'b1; WriteReg = r; WriteData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"}, A, 16'h0000);
    check({tag, "_B"}, B, 16'h0000);
    check({tag, "_Imm"}, Imm, 16'h0000);
    check({tag, "_ALUsrc"}, {15'd0, ALUsrc}, 16'h0000);
    check({tag, "_ALUop"}, {13'd0, ALUop}, 16'h0000);
    check({tag, "_valid"}, {15'd0, valid_out}, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0; rs_addr = '0; rt_addr = '0; imm_in = '0; imm_signed = 1'b0;
    alusrc_in = 1'b0; aluop_in = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    // write/read
    wr(4'd3, 16'h1234);
    wr(4'd5, 16'hBEEF);
    rs_addr = 4'd3; rt_addr = 4'd5; valid_in = 1'b1;
    tick();
    check("read_r3", A, 16'h1234);
    check("read_r5", B, 16'hBEEF);
    check("read_valid", {15'd0, valid_out}, 16'h0001);

    wr(4'd0, 16'hFFFF);
    rs_addr = 4'd0; rt_addr = 4'd0;
    tick();
    check("r0_A", A, 16'h0000);
    check("r0_B", B, 16'h0000);

    // bypass, then r0 bypass, then array holds bypassed write
    rs_addr = 4'd7; rt_addr = 4'd7;
    RegWrite = 1'b1; WriteReg = 4'd7; WriteData = 16'hA5A5;
    tick();
    check("byp_A", A, 16'hA5A5);
    check("byp_B", B, 16'hA5A5);
    rs_addr = 4'd0; rt_addr = 4'd0; WriteReg = 4'd0; WriteData = 16'h5A5A;
    tick();
    check("byp_r0_A", A, 16'h0000);
    check("byp_r0_B", B, 16'h0000);
    RegWrite = 1'b0; rs_addr = 4'd7; rt_addr = 4'd3;
    tick();
    check("array_r7", A, 16'hA5A5);
    check("array_r3", B, 16'h1234);

    // bypass on one port only while the other reads the array
    RegWrite = 1'b1; WriteReg = 4'd5; WriteData = 16'h0F0F; rs_addr = 4'd3; rt_addr = 4'd5;
    tick();
    RegWrite = 1'b0;
    check("byp_mix_A", A, 16'h1234);
    check("byp_mix_B", B, 16'h0F0F);

    // immediate extension
    imm_in = 8'h80; imm_signed = 1'b1;
    tick();
    check("imm_sx_80", Imm, 16'hFF80);
    imm_signed = 1'b0;
    tick();
    check("imm_zx_80", Imm, 16'h0080);
    imm_in = 8'h7F; imm_signed = 1'b1;
    tick();
    check("imm_sx_7f", Imm, 16'h007F);

    // stall: load A=0x0011, then hold for 3 cycles while inputs change
    wr(4'd1, 16'h0011);
    rs_addr = 4'd1; rt_addr = 4'd3; imm_in = 8'h12; imm_signed = 1'b0;
    aluop_in = 3'd2; alusrc_in = 1'b0; valid_in = 1'b1;
    tick();
    check("pre_stall_A", A, 16'h0011);
    check("pre_stall_valid", {15'd0, valid_out}, 16'h0001);
    stall = 1'b1; rs_addr = 4'd2; rt_addr = 4'd5; imm_in = 8'hFF; aluop_in = 3'd7;
    alusrc_in = 1'b1; valid_in = 1'b0;
    RegWrite = 1'b1; WriteReg = 4'd2; WriteData = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      RegWrite = 1'b0;
      check("stall_A", A, 16'h0011);
      check("stall_B", B, 16'h1234);
      check("stall_Imm", Imm, 16'h0012);
      check("stall_ALUop", {13'd0, ALUop}, 16'h0002);
      check("stall_ALUsrc", {15'd0, ALUsrc}, 16'h0000);
      check("stall_valid", {15'd0, valid_out}, 16'h0001);
    end
    stall = 1'b0; rs_addr = 4'd2; rt_addr = 4'd2; valid_in = 1'b1;
    tick();
    check("post_stall_A", A, 16'h2222);
    check("post_stall_B", B, 16'h2222);

    // flush overrides stall
    stall = 1'b1; flush = 1'b1;
    tick();
    check_all_zero("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // pass-through of decoded fields
    aluop_in = 3'b101; alusrc_in = 1'b1; valid_in = 1'b0; rs_addr = 4'd3;
    tick();
    check("pt_ALUop", {13'd0, ALUop}, 16'h0005);
    check("pt_ALUsrc", {15'd0, ALUsrc}, 16'h0001);
    check("pt_valid", {15'd0, valid_out}, 16'h0000);
    check("pt_A", A, 16'h1234);

    // asynchronous reset mid-cycle clears outputs without a clock edge
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    reset_n = 1'b1;
    aluop_in = '0; alusrc_in = 1'b0; imm_in = '0;
    for (int i = 0; i < 16; i++) begin
      rs_addr = 4'(i); rt_addr = 4'(15 - i);
      tick();
      check("rf_clear_A", A, 16'h0000);
      check("rf_clear_B", B, 16'h0000);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
